// File: rtl/axi_wr_arbiter_512.sv
// Round-robin arbiter sharing one AXI4 write port (AW/W/B) among NUM_REQ requesters, one
// transaction in flight. Define WR_ARB_STATS_EN to add per-requester completed-burst counters.
module axi_wr_arbiter_512 #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_WID  = 32,
    parameter int DATA_WID  = 512,
    parameter int BURST_LEN = 32
) (
    input  logic                        axi_clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          s_avalid,
    input  logic [NUM_REQ*ADDR_WID-1:0] s_addr,
    output logic [NUM_REQ-1:0]          s_aready,
    input  logic [NUM_REQ-1:0]          s_wvalid,
    input  logic [NUM_REQ*DATA_WID-1:0] s_wdata,
    input  logic [NUM_REQ-1:0]          s_wlast,
    output logic [NUM_REQ-1:0]          s_wready,
    input  logic [NUM_REQ-1:0]          s_bready,
    output logic [NUM_REQ-1:0]          s_bvalid,
    output logic                        m_avalid,
    output logic [ADDR_WID-1:0]         m_addr,
    input  logic                        m_aready,
    output logic                        m_wvalid,
    output logic [DATA_WID-1:0]         m_wdata,
    output logic                        m_wlast,
    input  logic                        m_wready,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        err_len
`ifdef WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       burst_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     last_q;
    logic                 m_avalid_q;
    logic [ADDR_WID-1:0]  m_addr_q;
    logic [7:0]           beat_cnt_q;
    logic                 err_len_q;

    logic [ADDR_WID-1:0]  addr_arr_s  [NUM_REQ];
    logic [DATA_WID-1:0]  wdata_arr_s [NUM_REQ];
    logic [IDX_W-1:0]     pick_s;
    logic                 any_req_s;
    logic                 aw_hs_s;
    logic                 w_hs_s;
    logic                 b_hs_s;

    // Search starts just after the previous owner; pointer arithmetic wraps at NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        int               c;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c    = int'(last) + k;
            c    = (c >= NUM_REQ) ? (c - NUM_REQ) : c;
            pick = req[c] ? c[IDX_W-1:0] : pick;
        end
        return pick;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr_s[i]  = s_addr[i*ADDR_WID +: ADDR_WID];
        assign wdata_arr_s[i] = s_wdata[i*DATA_WID +: DATA_WID];
    end

    assign pick_s    = rr_pick(s_avalid, last_q);
    assign any_req_s = |s_avalid;
    assign aw_hs_s   = (state_q == ST_ADDR) & m_avalid_q & m_aready;
    assign w_hs_s    = (state_q == ST_DATA) & s_wvalid[gidx_q] & m_wready;
    assign b_hs_s    = (state_q == ST_RESP) & m_bvalid & s_bready[gidx_q];

    // State register
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = any_req_s ? ST_ADDR : ST_IDLE;
            ST_ADDR: state_d = aw_hs_s ? ST_DATA : ST_ADDR;
            ST_DATA: state_d = (w_hs_s && s_wlast[gidx_q]) ? ST_RESP : ST_DATA;
            ST_RESP: state_d = b_hs_s ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pass-through routing to and from the granted requester only
    always_comb begin
        s_aready = {NUM_REQ{1'b0}};
        s_wready = {NUM_REQ{1'b0}};
        s_bvalid = {NUM_REQ{1'b0}};
        m_wvalid = 1'b0;
        m_wdata  = {DATA_WID{1'b0}};
        m_wlast  = 1'b0;
        m_bready = 1'b0;
        case (state_q)
            ST_ADDR: s_aready[gidx_q] = m_avalid_q & m_aready;
            ST_DATA: begin
                m_wvalid         = s_wvalid[gidx_q];
                m_wdata          = wdata_arr_s[gidx_q];
                m_wlast          = s_wlast[gidx_q];
                s_wready[gidx_q] = m_wready;
            end
            ST_RESP: begin
                m_bready         = s_bready[gidx_q];
                s_bvalid[gidx_q] = m_bvalid;
            end
            default: m_wvalid = 1'b0;
        endcase
    end

    // Grant, AW channel, beat counting and the sticky length error
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            grant_q    <= {NUM_REQ{1'b0}};
            gidx_q     <= {IDX_W{1'b0}};
            last_q     <= IDX_W'(NUM_REQ - 1);
            m_avalid_q <= 1'b0;
            m_addr_q   <= {ADDR_WID{1'b0}};
            beat_cnt_q <= 8'd0;
            err_len_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                        gidx_q     <= pick_s;
                        m_addr_q   <= addr_arr_s[pick_s];
                        m_avalid_q <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs_s) begin
                        m_avalid_q <= 1'b0;
                        beat_cnt_q <= 8'd0;
                    end
                end
                ST_DATA: begin
                    if (w_hs_s) begin
                        if (beat_cnt_q != 8'hFF) begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                        if (s_wlast[gidx_q] && ((int'(beat_cnt_q) + 1) != BURST_LEN)) begin
                            err_len_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_hs_s) begin
                        last_q  <= gidx_q;
                        grant_q <= {NUM_REQ{1'b0}};
                    end
                end
                default: grant_q <= {NUM_REQ{1'b0}};
            endcase
        end
    end

    assign grant    = grant_q;
    assign m_avalid = m_avalid_q;
    assign m_addr   = m_addr_q;
    assign err_len  = err_len_q;

`ifdef WR_ARB_STATS_EN
    logic [15:0] bcnt_q [NUM_REQ];

    // Completed B handshakes per requester, wrapping at 2^16
    always_ff @(posedge axi_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bcnt_q[i] <= 16'd0;
            end
        end else if (b_hs_s) begin
            bcnt_q[gidx_q] <= bcnt_q[gidx_q] + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        assign burst_cnt[i*16 +: 16] = bcnt_q[i];
    end
`endif

endmodule

// File: tb/tb_axi_wr_arbiter_512.sv
// Directed self-checking bench for axi_wr_arbiter_512 (two requesters, 512-bit data).
module tb_axi_wr_arbiter_512;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 512;

    logic             axi_clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    s_avalid, s_aready, s_wvalid, s_wlast, s_wready, s_bready, s_bvalid, grant;
    logic [NR*AW-1:0] s_addr;
    logic [NR*DW-1:0] s_wdata;
    logic             m_avalid, m_aready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready, err_len;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
`ifdef WR_ARB_STATS_EN
    logic [NR*16-1:0] burst_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 axi_clk = ~axi_clk;

    axi_wr_arbiter_512 dut (
        .axi_clk  (axi_clk),
        .rst      (rst),
        .s_avalid (s_avalid),
        .s_addr   (s_addr),
        .s_aready (s_aready),
        .s_wvalid (s_wvalid),
        .s_wdata  (s_wdata),
        .s_wlast  (s_wlast),
        .s_wready (s_wready),
        .s_bready (s_bready),
        .s_bvalid (s_bvalid),
        .m_avalid (m_avalid),
        .m_addr   (m_addr),
        .m_aready (m_aready),
        .m_wvalid (m_wvalid),
        .m_wdata  (m_wdata),
        .m_wlast  (m_wlast),
        .m_wready (m_wready),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .grant    (grant),
`ifdef WR_ARB_STATS_EN
        .burst_cnt(burst_cnt),
`endif
        .err_len  (err_len)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int r, input int b);
        logic [DW-1:0] p;
        for (int k = 0; k < DW/32; k++) begin
            p[k*32 +: 32] = {8'(r), 8'(b), 8'(k), 8'h5A};
        end
        return p;
    endfunction

    // One complete transaction for requester r; s_avalid[r] must already be set by the caller.
    task automatic xfer(input int r, input logic [AW-1:0] addr, input int nbeats, input int aw_dly,
                        input bit toggle, input bit gaps, input bit keep, input bit exp_err);
        int            n;
        int            beat;
        logic [NR-1:0] own;
        own    = '0;
        own[r] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (grant !== own && n < 10);
        chk("grant_latency", DW'(n), DW'(1));
        chk("grant", DW'(grant), DW'(own));
        chk("m_avalid_set", DW'(m_avalid), DW'(1'b1));
        chk("m_addr", DW'(m_addr), DW'(addr));
        // W presented before the AW handshake must be stalled
        s_wvalid[r] = 1'b1;
        m_wready    = 1'b1;
        for (int d = 0; d < aw_dly; d++) begin
            #1;
            chk("aw_hold", DW'(m_avalid), DW'(1'b1));
            chk("early_w_stalled", DW'({m_wvalid, s_wready}), DW'(0));
            step();
        end
        s_wvalid[r] = 1'b0;
        m_aready    = 1'b1;
        #1;
        chk("s_aready", DW'(s_aready), DW'(own));
        step();
        m_aready = 1'b0;
        if (!keep) s_avalid[r] = 1'b0;
        #1;
        chk("aw_done", DW'(m_avalid), DW'(1'b0));
        beat = 0;
        n    = 0;
        s_wdata[(1-r)*DW +: DW] = pat(1 - r, 200);
        while (beat < nbeats && n < 300) begin
            s_wvalid[r]          = !(gaps && (n % 3 == 2));
            s_wdata[r*DW +: DW]  = pat(r, beat);
            s_wlast[r]           = (beat == nbeats - 1);
            m_wready             = toggle ? (n % 2 == 0) : 1'b1;
            #1;
            chk("s_wready", DW'(s_wready), DW'(m_wready ? own : 2'b00));
            if (m_wvalid && m_wready) begin
                chk("wdata", m_wdata, pat(r, beat));
                chk("wlast", DW'(m_wlast), DW'(beat == nbeats - 1));
                beat++;
            end
            step();
            n++;
        end
        chk("beat_count", DW'(beat), DW'(nbeats));
        s_wvalid[r] = 1'b0;
        s_wlast[r]  = 1'b0;
        m_wready    = 1'b0;
        #1;
        chk("err_len", DW'(err_len), DW'(exp_err));
        m_bvalid    = 1'b1;
        s_bready[r] = 1'b1;
        #1;
        chk("s_bvalid_owner", DW'(s_bvalid), DW'(own));
        chk("m_bready", DW'(m_bready), DW'(1'b1));
        step();
        m_bvalid    = 1'b0;
        s_bready[r] = 1'b0;
        #1;
        chk("grant_after_b", DW'(grant), DW'(0));
        chk("err_len_hold", DW'(err_len), DW'(exp_err));
    endtask

    initial begin
        rst      = 1'b1;
        s_avalid = 2'b11;
        s_addr   = {32'h0000_1000, 32'h0000_0800};
        s_wvalid = '0;
        s_wdata  = '0;
        s_wlast  = '0;
        s_bready = '0;
        m_aready = 1'b0;
        m_wready = 1'b0;
        m_bvalid = 1'b0;

        // T1: reset held with both requests pending
        repeat (3) begin
            step();
            chk("rst_outputs", DW'({grant, s_aready, s_wready, s_bvalid, m_avalid, m_wvalid,
                                    m_wlast, m_bready, err_len}), DW'(0));
            chk("rst_m_addr", DW'(m_addr), DW'(0));
            chk("rst_m_wdata", m_wdata, DW'(0));
        end
        rst = 1'b0;

        // T1/T2: req0 wins first, delayed AW ready, 32 beats
        xfer(0, 32'h0000_0800, 32, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        // T3: continuous contention alternates owners
        s_avalid[0] = 1'b1;
        xfer(1, 32'h0000_1000, 32, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer(0, 32'h0000_0800, 32, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer(1, 32'h0000_1000, 32, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        xfer(0, 32'h0000_0800, 32, 1, 1'b0, 1'b0, 1'b1, 1'b0);

        // T4: req1 alone, W backpressure and wvalid gaps
        s_avalid        = 2'b10;
        s_addr[AW +: AW] = 32'h0000_2000;
        xfer(1, 32'h0000_2000, 32, 2, 1'b1, 1'b1, 1'b0, 1'b0);

        // T5: short burst raises the sticky length error
        s_avalid       = 2'b01;
        s_addr[0 +: AW] = 32'h0000_4000;
        xfer(0, 32'h0000_4000, 31, 1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef WR_ARB_STATS_EN
        chk("burst_cnt", DW'(burst_cnt), DW'(32'h0003_0004));
`endif

        // T6: reset in the middle of a data phase
        s_avalid         = 2'b10;
        s_addr[AW +: AW] = 32'h0000_3000;
        step();
        chk("t6_grant", DW'(grant), DW'(2'b10));
        m_aready = 1'b1;
        step();
        m_aready    = 1'b0;
        s_avalid    = 2'b00;
        s_wvalid[1] = 1'b1;
        m_wready    = 1'b1;
        for (int b = 0; b < 10; b++) begin
            s_wdata[DW +: DW] = pat(1, b);
            #1;
            chk("t6_beat", m_wdata, pat(1, b));
            step();
        end
        rst = 1'b1;
        step();
        chk("t6_m_wvalid", DW'(m_wvalid), DW'(1'b0));
        chk("t6_grant_clr", DW'(grant), DW'(0));
        chk("t6_s_wready", DW'(s_wready), DW'(0));
        chk("t6_err_clr", DW'(err_len), DW'(1'b0));
`ifdef WR_ARB_STATS_EN
        chk("t6_burst_cnt", DW'(burst_cnt), DW'(0));
`endif
        rst         = 1'b0;
        s_wvalid[1] = 1'b0;
        m_wready    = 1'b0;

        // Pointer back at its reset value: req0 wins a tie again
        s_avalid = 2'b11;
        step();
        chk("post_rst_grant", DW'(grant), DW'(2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
